// File: rtl/mult_pkg.sv
// Shared widths and the result entry carried from the multiplier to the CDB.
package mult_pkg;
  localparam int DATA_W        = 64;
  localparam int ROB_W         = 6;
  localparam int PRN_W         = 7;
  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [DATA_W-1:0] product;
    logic [ROB_W-1:0]  rob_num;
    logic [PRN_W-1:0]  dest_prn;
  } mult_result_t;
endpackage

// File: rtl/result_fifo.sv
// In-order circular FIFO of multiplier results; data visible 1 cycle after push.
// Push while full and pop while empty are ignored; flush empties it and beats both.
module result_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  mult_result_t i_wdat,
  input  logic         i_pop,
  output mult_result_t o_rdat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  mult_result_t  r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_rdat  = r_mem[r_head];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: nothing reads it until count says it is valid.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_tail] <= i_wdat;
  end
endmodule

// File: rtl/mult_cdb_buffer.sv
// Buffers multiplier results for the CDB in order; result on cdb_* 1 cycle after capture.
// mult_enable drops while full (registered count only), stalling the multiplier pipeline.
module mult_cdb_buffer
  import mult_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              mult_done,
  input  logic [DATA_W-1:0] mult_product,
  input  logic [ROB_W-1:0]  mult_ROB_num,
  input  logic [PRN_W-1:0]  mult_dest_PRN,
  output logic              mult_enable,
  input  logic              cdb_grant,
  output logic              cdb_req,
  output logic [DATA_W-1:0] cdb_value,
  output logic [ROB_W-1:0]  cdb_ROB_num,
  output logic [PRN_W-1:0]  cdb_dest_PRN
);
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  mult_result_t w_wdat;
  mult_result_t w_head;

  assign mult_enable = !w_full;
  assign cdb_req     = !w_empty;

  // A held done while stalled is never captured because enable gates the push.
  assign w_push = mult_done && mult_enable && !flush;
  assign w_pop  = cdb_grant && cdb_req && !flush;

  assign w_wdat.product  = mult_product;
  assign w_wdat.rob_num  = mult_ROB_num;
  assign w_wdat.dest_prn = mult_dest_PRN;

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_flush   (flush),
    .i_push    (w_push),
    .i_wdat    (w_wdat),
    .i_pop     (w_pop),
    .o_rdat    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_comb begin
    cdb_value    = '0;
    cdb_ROB_num  = '0;
    cdb_dest_PRN = '0;
    if (cdb_req) begin
      cdb_value    = w_head.product;
      cdb_ROB_num  = w_head.rob_num;
      cdb_dest_PRN = w_head.dest_prn;
    end
  end
endmodule

// File: tb/tb_mult_cdb_buffer.sv
// Directed self-checking bench for mult_cdb_buffer with hand-computed expectations.
module tb_mult_cdb_buffer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        mult_done = 1'b0;
  logic [63:0] mult_product = '0;
  logic [5:0]  mult_ROB_num = '0;
  logic [6:0]  mult_dest_PRN = '0;
  logic        mult_enable;
  logic        cdb_grant = 1'b0;
  logic        cdb_req;
  logic [63:0] cdb_value;
  logic [5:0]  cdb_ROB_num;
  logic [6:0]  cdb_dest_PRN;

  int checks = 0;
  int errors = 0;

  mult_cdb_buffer dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .mult_done     (mult_done),
    .mult_product  (mult_product),
    .mult_ROB_num  (mult_ROB_num),
    .mult_dest_PRN (mult_dest_PRN),
    .mult_enable   (mult_enable),
    .cdb_grant     (cdb_grant),
    .cdb_req       (cdb_req),
    .cdb_value     (cdb_value),
    .cdb_ROB_num   (cdb_ROB_num),
    .cdb_dest_PRN  (cdb_dest_PRN)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++; if (mult_enable !== 1'b1) begin errors++; $display("FAIL rst_enable got %0b want 1", mult_enable); end
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", cdb_req); end
    checks++; if (cdb_value !== 64'h0) begin errors++; $display("FAIL rst_value got %0h want 0", cdb_value); end
    checks++; if (cdb_ROB_num !== 6'h0) begin errors++; $display("FAIL rst_rob got %0h want 0", cdb_ROB_num); end
    checks++; if (cdb_dest_PRN !== 7'h0) begin errors++; $display("FAIL rst_prn got %0h want 0", cdb_dest_PRN); end
    reset = 1'b1;
    step();
    checks++; if (mult_enable !== 1'b1) begin errors++; $display("FAIL rel_enable got %0b want 1", mult_enable); end
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL rel_req got %0b want 0", cdb_req); end
  endtask

  task automatic test_single();
    mult_done = 1'b1; mult_product = 64'h0000_0000_0000_1234;
    mult_ROB_num = 6'd5; mult_dest_PRN = 7'h22; cdb_grant = 1'b1;
    step();
    mult_done = 1'b0;
    checks++; if (cdb_req !== 1'b1) begin errors++; $display("FAIL single_req got %0b want 1", cdb_req); end
    checks++; if (cdb_value !== 64'h1234) begin errors++; $display("FAIL single_value got %0h want 1234", cdb_value); end
    checks++; if (cdb_ROB_num !== 6'd5) begin errors++; $display("FAIL single_rob got %0d want 5", cdb_ROB_num); end
    checks++; if (cdb_dest_PRN !== 7'h22) begin errors++; $display("FAIL single_prn got %0h want 22", cdb_dest_PRN); end
    step();
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL single_gone got %0b want 0", cdb_req); end
    checks++; if (cdb_value !== 64'h0) begin errors++; $display("FAIL single_zero got %0h want 0", cdb_value); end
    cdb_grant = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      mult_done = 1'b1; mult_ROB_num = 6'(i);
      mult_product = 64'hF000 + 64'(i); mult_dest_PRN = 7'(i);
      step();
    end
    checks++; if (mult_enable !== 1'b0) begin errors++; $display("FAIL full_enable got %0b want 0", mult_enable); end
    checks++; if (cdb_ROB_num !== 6'd0) begin errors++; $display("FAIL full_head got %0d want 0", cdb_ROB_num); end
    mult_ROB_num = 6'd4; mult_product = 64'hF004; mult_dest_PRN = 7'd4;
    step();
    step();
    checks++; if (mult_enable !== 1'b0) begin errors++; $display("FAIL hold_enable got %0b want 0", mult_enable); end
    checks++; if (cdb_ROB_num !== 6'd0) begin errors++; $display("FAIL hold_head got %0d want 0", cdb_ROB_num); end
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    checks++; if (mult_enable !== 1'b1) begin errors++; $display("FAIL pop_enable got %0b want 1", mult_enable); end
    checks++; if (cdb_ROB_num !== 6'd1) begin errors++; $display("FAIL pop_head got %0d want 1", cdb_ROB_num); end
    step();
    mult_done = 1'b0;
    checks++; if (mult_enable !== 1'b0) begin errors++; $display("FAIL refill_enable got %0b want 0", mult_enable); end
    cdb_grant = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (cdb_req !== 1'b1 || cdb_ROB_num !== 6'(k)) begin errors++; $display("FAIL drain_%0d got req %0b rob %0d want req 1 rob %0d", k, cdb_req, cdb_ROB_num, k); end
      checks++; if (cdb_value !== 64'hF000 + 64'(k)) begin errors++; $display("FAIL drain_val_%0d got %0h want %0h", k, cdb_value, 64'hF000 + 64'(k)); end
      step();
    end
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", cdb_req); end
    checks++; if (mult_enable !== 1'b1) begin errors++; $display("FAIL drain_enable got %0b want 1", mult_enable); end
    cdb_grant = 1'b0;
  endtask

  task automatic test_back_to_back();
    mult_done = 1'b1; mult_ROB_num = 6'd10; mult_product = 64'hB10;
    step();
    mult_ROB_num = 6'd11; mult_product = 64'hB11;
    step();
    mult_ROB_num = 6'd12; mult_product = 64'hB12; cdb_grant = 1'b1;
    step();
    checks++; if (cdb_req !== 1'b1 || cdb_ROB_num !== 6'd11) begin errors++; $display("FAIL b2b_a got req %0b rob %0d want req 1 rob 11", cdb_req, cdb_ROB_num); end
    mult_ROB_num = 6'd13; mult_product = 64'hB13;
    step();
    mult_done = 1'b0;
    checks++; if (cdb_req !== 1'b1 || cdb_ROB_num !== 6'd12) begin errors++; $display("FAIL b2b_b got req %0b rob %0d want req 1 rob 12", cdb_req, cdb_ROB_num); end
    checks++; if (cdb_value !== 64'hB12) begin errors++; $display("FAIL b2b_val got %0h want b12", cdb_value); end
    step();
    checks++; if (cdb_req !== 1'b1 || cdb_ROB_num !== 6'd13) begin errors++; $display("FAIL b2b_c got req %0b rob %0d want req 1 rob 13", cdb_req, cdb_ROB_num); end
    step();
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", cdb_req); end
    cdb_grant = 1'b0;
  endtask

  task automatic test_wrap();
    int q[$];
    int next_push = 0;
    int exp_pop = 0;
    int cyc = 0;
    int sz;
    logic g = 1'b0;
    while (exp_pop < 10 && cyc < 80) begin
      mult_done    = (next_push < 10);
      mult_ROB_num = 6'(next_push);
      mult_product = 64'hA5A5_0000_0000_0000 | 64'(next_push);
      cdb_grant    = g;
      sz = q.size();
      checks++; if (cdb_req !== (sz != 0)) begin errors++; $display("FAIL wrap_req c%0d got %0b want %0b", cyc, cdb_req, (sz != 0)); end
      checks++; if (mult_enable !== (sz != 4)) begin errors++; $display("FAIL wrap_enable c%0d got %0b want %0b", cyc, mult_enable, (sz != 4)); end
      if (g && sz != 0) begin
        checks++; if (cdb_ROB_num !== 6'(exp_pop) || cdb_value !== (64'hA5A5_0000_0000_0000 | 64'(exp_pop))) begin
          errors++; $display("FAIL wrap_order got rob %0d val %0h want rob %0d", cdb_ROB_num, cdb_value, exp_pop);
        end
        void'(q.pop_front());
        exp_pop++;
      end
      if (mult_done && sz != 4) begin
        q.push_back(next_push);
        next_push++;
      end
      step();
      g = ~g;
      cyc++;
    end
    mult_done = 1'b0; cdb_grant = 1'b0;
    checks++; if (exp_pop != 10) begin errors++; $display("FAIL wrap_timeout got %0d pops want 10", exp_pop); end
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL wrap_dup got req %0b want 0", cdb_req); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      mult_done = 1'b1; mult_ROB_num = 6'(20 + i); mult_product = 64'hC00 + 64'(i);
      step();
    end
    mult_ROB_num = 6'd23; mult_product = 64'hC03; flush = 1'b1;
    step();
    flush = 1'b0; mult_done = 1'b0;
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL flush_req got %0b want 0", cdb_req); end
    checks++; if (mult_enable !== 1'b1) begin errors++; $display("FAIL flush_enable got %0b want 1", mult_enable); end
    checks++; if (cdb_value !== 64'h0 || cdb_ROB_num !== 6'h0) begin errors++; $display("FAIL flush_out got %0h/%0d want 0/0", cdb_value, cdb_ROB_num); end
    step();
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL flush_drop got %0b want 0", cdb_req); end
    mult_done = 1'b1; mult_ROB_num = 6'd30; mult_product = 64'hC30;
    step();
    mult_done = 1'b0;
    checks++; if (cdb_req !== 1'b1 || cdb_ROB_num !== 6'd30) begin errors++; $display("FAIL flush_after got req %0b rob %0d want req 1 rob 30", cdb_req, cdb_ROB_num); end
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL flush_after_pop got %0b want 0", cdb_req); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      mult_done = 1'b1; mult_ROB_num = 6'(40 + i); mult_product = 64'hD00 + 64'(i); mult_dest_PRN = 7'h55;
      step();
    end
    mult_done = 1'b0;
    checks++; if (cdb_req !== 1'b1 || cdb_ROB_num !== 6'd40) begin errors++; $display("FAIL mid_pre got req %0b rob %0d want req 1 rob 40", cdb_req, cdb_ROB_num); end
    #2 reset = 1'b0;
    #1;
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL mid_req got %0b want 0", cdb_req); end
    checks++; if (cdb_value !== 64'h0 || cdb_ROB_num !== 6'h0 || cdb_dest_PRN !== 7'h0) begin
      errors++; $display("FAIL mid_out got %0h/%0d/%0h want 0/0/0", cdb_value, cdb_ROB_num, cdb_dest_PRN);
    end
    checks++; if (mult_enable !== 1'b1) begin errors++; $display("FAIL mid_enable got %0b want 1", mult_enable); end
    reset = 1'b1;
    step();
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL mid_after got %0b want 0", cdb_req); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
